// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin owned 8:1 datapath arbiter.
package mux_rr_arbiter_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_pick_t;

   // Round-robin search: first set request at last+1, last+2, ... (mod N_REQ).
   // Candidates are visited from lowest to highest priority so the closest one wins.
   function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                        input logic [SEL_W-1:0] last);
      rr_pick_t         p;
      logic [SEL_W-1:0] cand;
      p = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = last + SEL_W'(N_REQ - k);
         if (req[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux8.sv
// 8:1 single-bit mux built from two 4:1 stages and a final 2:1 on the select MSB.
module mux_8to1_by_4to1
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] i_d,
   input  logic [2:0]       i_sel,
   output logic             o_y
);

   logic w_lo;
   logic w_hi;

   function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
      return d[s];
   endfunction

   // Two 4:1 halves, then pick the half with the select MSB.
   always_comb begin
      w_lo = mux4(i_d[3:0], i_sel[1:0]);
      w_hi = mux4(i_d[7:4], i_sel[1:0]);
      o_y  = i_sel[2] ? w_hi : w_lo;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a shared 8:1 datapath, with bounded hold time
// and a one-cycle dead gap between owners.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] a,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             y
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_hold;
   logic [3:0]       w_hold_nxt;
   logic [SEL_W-1:0] r_last;
   logic [SEL_W-1:0] w_last_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] w_gnt_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   rr_pick_t         w_pick;

   assign gnt  = r_gnt;
   assign sel  = r_sel;
   assign busy = r_busy;

   // Winner search from the previous owner, purely combinational.
   always_comb begin
      w_pick = rr_pick(req, r_last);
   end

   // Next-state and next registered outputs; everything holds unless changed.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_last_nxt  = r_last;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_busy_nxt  = r_busy;
      case (r_state)
         ST_GRANT: begin
            if (!req[r_sel] || (r_hold == HOLD_LAST)) begin
               w_state_nxt = ST_GAP;
               w_gnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_last_nxt  = r_sel;
            end else begin
               w_hold_nxt = r_hold + 4'd1;
            end
         end
         default: begin
            // IDLE and GAP arbitrate identically; GAP only exists to force a dead cycle.
            if (w_pick.found) begin
               w_state_nxt = ST_GRANT;
               w_gnt_nxt   = N_REQ'(1) << w_pick.idx;
               w_sel_nxt   = w_pick.idx;
               w_busy_nxt  = 1'b1;
               w_hold_nxt  = '0;
            end else begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 0 first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_last  <= 3'd7;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_last  <= w_last_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   mux_8to1_by_4to1 u_mux (
      .i_d   (a),
      .i_sel (r_sel),
      .o_y   (y)
   );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) driven by
// the same inputs, checked cycle by cycle against an ownership-level model.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic [7:0] a   = '0;

   logic [7:0] w_gnt  [2];
   logic [2:0] w_sel  [2];
   logic       w_busy [2];
   logic       w_y    [2];

   mux_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
      .clk(clk), .rst(rst), .req(req), .a(a),
      .gnt(w_gnt[0]), .sel(w_sel[0]), .busy(w_busy[0]), .y(w_y[0])
   );

   mux_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .a(a),
      .gnt(w_gnt[1]), .sel(w_sel[1]), .busy(w_busy[1]), .y(w_y[1])
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: owner index (-1 when free), cycles already held, previous owner, shown index.
   int         mh      [2] = '{4, 1};
   int         m_owner [2];
   int         m_cnt   [2];
   int         m_last  [2];
   int         m_sel   [2];
   logic [7:0] prev_gnt[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k]  = -1;
         m_cnt[k]    = 0;
         m_last[k]   = 7;
         m_sel[k]    = 0;
         prev_gnt[k] = '0;
      end
   endtask

   task automatic model_step(input int k, input logic [7:0] r);
      bit found;
      int c;
      if (m_owner[k] >= 0) begin
         if (r[m_owner[k]] == 1'b0 || m_cnt[k] == mh[k] - 1) begin
            m_last[k]  = m_owner[k];
            m_owner[k] = -1;
         end else begin
            m_cnt[k]++;
         end
      end else if (r != 8'h00) begin
         found = 1'b0;
         for (int off = 1; off <= 8; off++) begin
            c = (m_last[k] + off) % 8;
            if (!found && r[c]) begin
               found      = 1'b1;
               m_owner[k] = c;
               m_sel[k]   = c;
               m_cnt[k]   = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [7:0] e_gnt;
      for (int k = 0; k < 2; k++) begin
         e_gnt = (m_owner[k] >= 0) ? (8'd1 << m_owner[k]) : 8'd0;
         check_eq($sformatf("gnt[mh=%0d]", mh[k]), w_gnt[k], e_gnt);
         check_eq($sformatf("sel[mh=%0d]", mh[k]), w_sel[k], m_sel[k]);
         check_eq($sformatf("busy[mh=%0d]", mh[k]), w_busy[k], m_owner[k] >= 0);
         check_eq($sformatf("y[mh=%0d]", mh[k]), w_y[k], a[m_sel[k]]);
         check_eq($sformatf("bbm[mh=%0d]", mh[k]),
                  (prev_gnt[k] != 0) && (w_gnt[k] != 0) && (prev_gnt[k] != w_gnt[k]), 1'b0);
         prev_gnt[k] = w_gnt[k];
      end
   endtask

   task automatic tick(input logic [7:0] r, input logic [7:0] d);
      req = r;
      a   = d;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, r);
      #1;
      compare_all();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;
   endtask

   logic [7:0] r_cur;
   logic [7:0] e;
   int         pos;
   int         idx;

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      // Rotation with all requesters active: owners 0..7,0 with a gap after each grant.
      for (int c = 1; c <= 45; c++) begin
         tick(8'hFF, 8'($urandom));
         for (int k = 0; k < 2; k++) begin
            pos = (c - 1) % (mh[k] + 1);
            idx = ((c - 1) / (mh[k] + 1)) % 8;
            e   = (pos < mh[k]) ? (8'd1 << idx) : 8'd0;
            check_eq($sformatf("rot[mh=%0d]", mh[k]), w_gnt[k], e);
         end
      end

      // Reset in the middle of a grant held by requester 4.
      reset_pulse();
      tick(8'h10, 8'h00);
      tick(8'h10, 8'h00);
      check_eq("pre_rst_gnt", w_gnt[0], 8'h10);
      reset_pulse();
      check_eq("post_rst_sel", w_sel[0], 3'd0);

      // Single requester: fixed grant/gap cadence, sel stays on 2.
      for (int c = 1; c <= 12; c++) begin
         tick(8'h04, 8'($urandom));
         for (int k = 0; k < 2; k++) begin
            pos = (c - 1) % (mh[k] + 1);
            e   = (pos < mh[k]) ? 8'h04 : 8'h00;
            check_eq($sformatf("single[mh=%0d]", mh[k]), w_gnt[k], e);
            check_eq($sformatf("single_sel[mh=%0d]", mh[k]), w_sel[k], 3'd2);
         end
      end

      // Early release by owner 3 with requester 5 waiting.
      reset_pulse();
      tick(8'h28, 8'h00);
      tick(8'h28, 8'h00);
      check_eq("early_own3", w_gnt[0], 8'h08);
      tick(8'h20, 8'h00);
      check_eq("early_gap", w_gnt[0], 8'h00);
      tick(8'h20, 8'h00);
      check_eq("early_own5", w_gnt[0], 8'h20);

      // Wrap: owner 6 expires, then 6 and 0 both request during the gap.
      reset_pulse();
      for (int c = 0; c < 4; c++) tick(8'h40, 8'h00);
      check_eq("wrap_own6", w_gnt[0], 8'h40);
      tick(8'h41, 8'h00);
      check_eq("wrap_gap", w_gnt[0], 8'h00);
      tick(8'h41, 8'h00);
      check_eq("wrap_win0", w_gnt[0], 8'h01);

      // Datapath follows a[sel] combinationally.
      reset_pulse();
      tick(8'h20, 8'h20);
      check_eq("dp_y_set", w_y[0], 1'b1);
      a = 8'h00;
      #1;
      check_eq("dp_y_flip", w_y[0], 1'b0);
      compare_all();
      a = 8'h10;
      #1;
      check_eq("dp_y_other", w_y[0], 1'b0);
      compare_all();

      // Randomized traffic with sticky requests and occasional resets.
      r_cur = '0;
      for (int c = 0; c < 1500; c++) begin
         r_cur = r_cur ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(15) == 0) r_cur = '0;
         if ($urandom_range(199) == 0) reset_pulse();
         tick(r_cur, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
